vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Shares a single-port framebuffer block RAM between display scanout and a host read/write port.
- Sits between the VGA timing generator (sx, sy, de, hsync, vsync) and the palette/output stage.
- Fetches one packed framebuffer word every SCALE*PPW screen pixels during the active region and unpacks it into a pixel index stream. Sync signals are delayed to match.
- All remaining memory cycles go to the host under a req/ack handshake.

Parameters:
- H_RES, 640, active screen width in pixels.
- V_RES, 480, active screen height in lines.
- SCALE, 4, screen pixels per framebuffer pixel in each axis (power of 2).
- BPP, 2, bits per framebuffer pixel.
- DW, 16, memory word width. PPW = DW/BPP = 8 pixels per word (power of 2).
- AW, 12, memory address width. Must satisfy 2^AW >= (H_RES/SCALE/PPW) * (V_RES/SCALE).
- Derived: WPR = H_RES/(SCALE*PPW) = 20 words per framebuffer row. FETCH = SCALE*PPW = 32.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- sx  in  10  horizontal count from timing generator
- sy  in  10  vertical count from timing generator
- de  in  1  active-region flag from timing generator
- hsync  in  1  active-low hsync from timing generator
- vsync  in  1  active-low vsync from timing generator
- mem_addr  out  AW  RAM address, combinational in grant cycle
- mem_re  out  1  RAM read strobe
- mem_we  out  1  RAM write strobe
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_re
- host_req  in  1  host request; held with host_we/host_addr/host_wdata stable until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  AW  host word address
- host_wdata  in  DW  host write data
- host_ack  out  1  one-cycle pulse: request accepted
- host_rdata  out  DW  read data
- host_rvalid  out  1  one-cycle pulse: host_rdata valid
- pix  out  BPP  pixel colour index
- pix_de  out  1  de delayed 2 cycles
- pix_hsync  out  1  hsync delayed 2 cycles
- pix_vsync  out  1  vsync delayed 2 cycles

Behaviour:
- Reset:
  - Registered outputs return to 0: host_ack, host_rvalid, host_rdata, pix, pix_de.
  - pix_hsync and pix_vsync return to 1 (inactive).
  - mem_re and mem_we are forced to 0 while rst is high.
  - The grant history and the held-word register are cleared. An in-flight host read is dropped with no rvalid.
- Display slot: cycle where de=1 and sx mod FETCH == 0.
  - Display always wins the slot.
  - mem_re=1, mem_addr = (sy/SCALE)*WPR + sx/FETCH.
- Host grant: host_req=1, not a display slot, and no host grant in the previous cycle.
  - The previous-cycle block gives a one-cycle turnaround, so the held request is never granted twice.
  - Maximum host throughput is one transaction per 2 cycles.
- Host transaction timing, for a grant in cycle t:
  - Cycle t: mem_addr = host_addr. mem_we = host_we, mem_wdata = host_wdata, mem_re = !host_we.
  - Cycle t+1: host_ack = 1.
  - Reads only, cycle t+2: host_rdata = mem_rdata captured at t+1, host_rvalid = 1.
  - The host may drop the request or present a new one in the ack cycle. A new request is granted no earlier than t+2.
- Idle cycles (no display slot, no host grant): mem_re = mem_we = 0. mem_addr is don't-care but driven deterministically to 0.
- Pixel pipeline: fixed latency of 2 cycles from sx/sy/de/hsync/vsync to the pix* outputs.
  - Display read issued at t, data at t+1.
  - At t+1 the word register loads mem_rdata. pix (registered) takes pixel 0 directly from mem_rdata, visible at t+2.
  - Later pixels of the group come from the held word register.
  - Pixel index within word = (sx/SCALE) mod PPW, using sx delayed 1 cycle.
  - Pixel k occupies bits [k*BPP+BPP-1 : k*BPP], LSB first.
  - pix = 0 whenever the 1-cycle-delayed de is 0.
- Host reads never disturb the display word register. Display reads never assert host_rvalid.
- No framebuffer address exceeds WPR*(V_RES/SCALE)-1 = 2399. Host addresses are passed through unchecked.

Test Plan:
- Reset: hold rst 3 cycles with host_req=1, de=1, sx=0. Response: mem_re = mem_we = host_ack = host_rvalid = pix = pix_de = 0; pix_hsync = pix_vsync = 1.
- Scanout: word 0 = 16'hE4E4, sy=0, sx=0..31. Response: mem_re with addr 0 at sx=0 only; pix sequence 0,1,2,3,0,1,2,3, each held 4 cycles, starting 2 cycles after sx=0.
- Address math: sy=5, sx=32 -> mem_addr 21; sy=479, sx=608 -> mem_addr 2399. No display read at sx=33..63 or while de=0.
- Collision: host write (addr 7, 16'h1234) raised in the cycle sx=64, de=1. Response: slot goes to display; mem_we at sx=65 with addr 7; host_ack at sx=66.
- Host read in blanking: addr 100 holds 16'hBEEF, req held through ack. Response: mem_re at t, host_ack at t+1, host_rvalid with host_rdata = 16'hBEEF at t+2, no memory access at t+1. With a second read queued, its next grant is at t+2.
- Sync alignment and mid-operation reset: over a full frame, pix_de/pix_hsync/pix_vsync equal the inputs delayed by exactly 2 cycles. Asserting rst the cycle after a host read grant yields no host_rvalid.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// -----------------------------------------------------------------------------
// vga_fb_arbiter_if
// Host-side request/acknowledge bus of the framebuffer arbiter.
//   req    : request, held with we/addr/wdata stable until ack
//   we     : 1 = write, 0 = read
//   addr   : framebuffer word address
//   wdata  : write data
//   ack    : one-cycle pulse, request accepted
//   rdata  : read data
//   rvalid : one-cycle pulse, rdata valid
// Modports: master = host, slave = arbiter.
// -----------------------------------------------------------------------------
interface vga_fb_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;
    logic          rvalid;

    modport master (output req, we, addr, wdata, input ack, rdata, rvalid);
    modport slave  (input req, we, addr, wdata, output ack, rdata, rvalid);
endinterface

// File: rtl/vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// vga_fb_arbiter
// Shares one single-port framebuffer RAM between VGA scanout and a host port.
// Every FETCH screen pixels of the active region the display reads one packed
// word and unpacks it into a pixel-index stream; all other cycles may serve
// the host, with a one-cycle turnaround after each host grant.
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   i_sx, i_sy, i_de    timing generator counters and active flag
//   i_hsync, i_vsync    active-low syncs from the timing generator
//   o_mem_*             RAM address/strobes/write data (combinational)
//   i_mem_rdata         RAM read data, valid the cycle after o_mem_re
//   host                host request bus (slave side)
//   o_pix               pixel colour index, 2 cycles after the inputs
//   o_pix_de/hsync/vsync  de/syncs delayed 2 cycles
// -----------------------------------------------------------------------------
module vga_fb_arbiter #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int SCALE = 4,
    parameter int BPP   = 2,
    parameter int DW    = 16,
    parameter int AW    = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [9:0]      i_sx,
    input  logic [9:0]      i_sy,
    input  logic            i_de,
    input  logic            i_hsync,
    input  logic            i_vsync,
    output logic [AW-1:0]   o_mem_addr,
    output logic            o_mem_re,
    output logic            o_mem_we,
    output logic [DW-1:0]   o_mem_wdata,
    input  logic [DW-1:0]   i_mem_rdata,
    vga_fb_arbiter_if.slave host,
    output logic [BPP-1:0]  o_pix,
    output logic            o_pix_de,
    output logic            o_pix_hsync,
    output logic            o_pix_vsync
);
    localparam int PPW      = DW / BPP;
    localparam int FETCH    = SCALE * PPW;
    localparam int WPR      = H_RES / FETCH;
    localparam int SCALE_LG = $clog2(SCALE);
    localparam int FETCH_LG = $clog2(FETCH);
    localparam int PPW_LG   = $clog2(PPW);

    logic              w_disp_slot;
    logic              w_host_grant;
    logic [AW-1:0]     w_disp_addr;
    logic [DW-1:0]     w_src;
    logic [BPP-1:0]    w_pix;

    logic              r_ack;       // also the "granted last cycle" history
    logic              r_host_rd;
    logic              r_rvalid;
    logic [DW-1:0]     r_rdata;
    logic              r_disp_rd;
    logic [DW-1:0]     r_word;
    logic [PPW_LG-1:0] r_pix_idx;
    logic              r_de_d1;
    logic              r_hs_d1;
    logic              r_vs_d1;
    logic [BPP-1:0]    r_pix;
    logic              r_pix_de;
    logic              r_pix_hs;
    logic              r_pix_vs;

    // The line guard keeps display addresses inside the framebuffer even if
    // de were ever raised outside the visible lines.
    assign w_disp_slot  = i_de && (int'(i_sy) < V_RES) && (i_sx[FETCH_LG-1:0] == '0);
    assign w_host_grant = host.req && !w_disp_slot && !r_ack;
    assign w_disp_addr  = AW'(int'(i_sy >> SCALE_LG) * WPR + int'(i_sx >> FETCH_LG));

    // Pixel 0 of a group comes straight from the RAM in the cycle the word
    // arrives; the rest come from the held copy.
    assign w_src = r_disp_rd ? i_mem_rdata : r_word;
    assign w_pix = w_src[int'(r_pix_idx)*BPP +: BPP];

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_mem_addr  = '0;
        o_mem_re    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        if (!rst) begin
            if (w_disp_slot) begin
                o_mem_addr = w_disp_addr;
                o_mem_re   = 1'b1;
            end else if (w_host_grant) begin
                o_mem_addr  = host.addr;
                o_mem_we    = host.we;
                o_mem_re    = !host.we;
                o_mem_wdata = host.wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            // NOTE: the held word and pixel-index register are plain flops, so
            // clearing them is cheap and keeps post-reset output deterministic.
            r_ack     <= 1'b0;
            r_host_rd <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_disp_rd <= 1'b0;
            r_word    <= '0;
            r_pix_idx <= '0;
            r_de_d1   <= 1'b0;
            r_hs_d1   <= 1'b1;
            r_vs_d1   <= 1'b1;
            r_pix     <= '0;
            r_pix_de  <= 1'b0;
            r_pix_hs  <= 1'b1;
            r_pix_vs  <= 1'b1;
        end else begin
            r_ack     <= w_host_grant;
            r_host_rd <= w_host_grant && !host.we;
            r_rvalid  <= r_host_rd;
            if (r_host_rd) begin
                r_rdata <= i_mem_rdata;
            end
            r_disp_rd <= w_disp_slot;
            if (r_disp_rd) begin
                r_word <= i_mem_rdata;
            end
            r_pix_idx <= i_sx[SCALE_LG +: PPW_LG];
            r_de_d1   <= i_de;
            r_hs_d1   <= i_hsync;
            r_vs_d1   <= i_vsync;
            r_pix     <= r_de_d1 ? w_pix : '0;
            r_pix_de  <= r_de_d1;
            r_pix_hs  <= r_hs_d1;
            r_pix_vs  <= r_vs_d1;
        end
    end

    assign host.ack    = r_ack;
    assign host.rdata  = r_rdata;
    assign host.rvalid = r_rvalid;
    assign o_pix       = r_pix;
    assign o_pix_de    = r_pix_de;
    assign o_pix_hsync = r_pix_hs;
    assign o_pix_vsync = r_pix_vs;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_arbiter
// Directed stimulus for vga_fb_arbiter with a RAM model, a host agent, and a
// behavioural reference: expected RAM accesses, host responses and pixels are
// derived from the raster position, the host request stream and a reference
// copy of the framebuffer.
// -----------------------------------------------------------------------------
module tb_vga_fb_arbiter;
    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [9:0]    sx = '0, sy = '0;
    logic          de = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic [AW-1:0] mem_addr;
    logic          mem_re, mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    pix;
    logic          pix_de, pix_hsync, pix_vsync;

    vga_fb_arbiter_if #(.AW(AW), .DW(DW)) hif();

    vga_fb_arbiter dut (
        .clk(clk), .rst(rst),
        .i_sx(sx), .i_sy(sy), .i_de(de), .i_hsync(hsync), .i_vsync(vsync),
        .o_mem_addr(mem_addr), .o_mem_re(mem_re), .o_mem_we(mem_we),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .host(hif),
        .o_pix(pix), .o_pix_de(pix_de), .o_pix_hsync(pix_hsync), .o_pix_vsync(pix_vsync)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM model and reference framebuffer ----------------
    logic [DW-1:0] ram    [4096];
    logic [DW-1:0] ref_fb [4096];

    initial begin
        mem_rdata = '0;
        for (int i = 0; i < 4096; i++) begin
            ram[i]    = 16'($urandom);
            ref_fb[i] = ram[i];
        end
        ram[0]    = 16'hE4E4;
        ref_fb[0] = 16'hE4E4;
        forever begin
            @(posedge clk);
            if (mem_we) ram[mem_addr] = mem_wdata;
            if (mem_re) mem_rdata <= ram[mem_addr];
            else        mem_rdata <= 16'($urandom);
        end
    end

    // ---------------- host agent ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } host_t;
    host_t hq[$];
    bit    h_busy = 1'b0;
    int    h_wait = 0;

    task automatic host_push(input logic we, input int addr, input logic [DW-1:0] data);
        host_t t;
        t.we = we; t.addr = AW'(addr); t.data = data;
        hq.push_back(t);
    endtask

    task automatic host_apply();
        host_t t;
        if (!h_busy) begin
            if (hq.size() > 0) begin
                t = hq.pop_front();
                hif.req = 1'b1; hif.we = t.we; hif.addr = t.addr; hif.wdata = t.data;
                h_busy = 1'b1; h_wait = 0;
            end else begin
                hif.req = 1'b0;
            end
        end
    endtask

    task automatic host_ack_sample();
        if (h_busy) begin
            if (hif.ack) begin
                h_busy = 1'b0;
            end else begin
                h_wait++;
                if (h_wait > 100) begin
                    n_checks++; n_fail++;
                    $display("FAIL host_ack_timeout: no ack after %0d cycles, required within 100", h_wait);
                    h_busy = 1'b0;
                end
            end
        end
    endtask

    // ---------------- cycle helpers ----------------
    task automatic cyc_begin(input int x, input int y, input logic d, input logic h, input logic v);
        sx = 10'(x); sy = 10'(y); de = d; hsync = h; vsync = v;
        host_apply();
        @(negedge clk);
        host_ack_sample();
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input int x, input int y, input logic d, input logic h, input logic v);
        cyc_begin(x, y, d, h, v);
        cyc_end();
    endtask

    task automatic blank(input int n);
        repeat (n) cycle(700, 500, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic host_drain();
        int k = 0;
        while ((hq.size() > 0 || h_busy) && k < 300) begin
            blank(1);
            k++;
        end
        check("host_drain", 32'(hq.size() == 0 && !h_busy), 1);
    endtask

    task automatic raster_line(input int y);
        for (int x = 0; x < 800; x++)
            cycle(x, y, (x < 640) && (y < 480), !((x >= 656) && (x < 752)), !((y == 490) || (y == 491)));
    endtask

    // ---------------- behavioural reference, checked every cycle ----------------
    bit            pix_chk_en = 1'b0;
    int            mc = 0;
    logic          h_rst [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic          h_gnt [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic          h_gwe [4];
    logic          h_de  [4];
    logic          h_hs  [4];
    logic          h_vs  [4];
    logic [9:0]    h_sx  [4];
    logic [9:0]    h_sy  [4];
    logic [DW-1:0] h_rdx [4];

    initial begin
        int c0, c1, c2, idx, fb_addr;
        logic slot, gnt, rd2;
        logic [DW-1:0] w;
        forever begin
            @(negedge clk);
            c0 = mc % 4; c1 = (mc + 3) % 4; c2 = (mc + 2) % 4;
            slot    = de && (sx % 32 == 0);
            fb_addr = (int'(sy) / 4) * 20 + int'(sx) / 32;
            gnt     = !rst && hif.req && !slot && !h_gnt[c1];

            if (rst) begin
                check("rst_mem_re", mem_re, 0);
                check("rst_mem_we", mem_we, 0);
            end else if (slot) begin
                check("disp_re", mem_re, 1);
                check("disp_we", mem_we, 0);
                check("disp_addr", mem_addr, fb_addr);
            end else if (gnt) begin
                check("host_addr", mem_addr, hif.addr);
                check("host_we", mem_we, hif.we);
                check("host_re", mem_re, !hif.we);
                if (hif.we) check("host_wdata", mem_wdata, hif.wdata);
            end else begin
                check("idle_re", mem_re, 0);
                check("idle_we", mem_we, 0);
                check("idle_addr", mem_addr, 0);
            end

            if (h_rst[c1]) begin
                check("ack_after_rst", hif.ack, 0);
                check("rvalid_after_rst", hif.rvalid, 0);
                check("rdata_after_rst", hif.rdata, 0);
            end else begin
                rd2 = h_gnt[c2] && !h_gwe[c2];
                check("ack", hif.ack, h_gnt[c1]);
                check("rvalid", hif.rvalid, rd2);
                if (rd2) check("rdata", hif.rdata, h_rdx[c2]);
            end

            if (h_rst[c1] || h_rst[c2]) begin
                check("pix_rst", pix, 0);
                check("pix_de_rst", pix_de, 0);
                check("pix_hsync_rst", pix_hsync, 1);
                check("pix_vsync_rst", pix_vsync, 1);
            end else begin
                check("pix_de", pix_de, h_de[c2]);
                check("pix_hsync", pix_hsync, h_hs[c2]);
                check("pix_vsync", pix_vsync, h_vs[c2]);
                if (!h_de[c2]) begin
                    check("pix_blank", pix, 0);
                end else if (pix_chk_en) begin
                    w   = ref_fb[(int'(h_sy[c2]) / 4) * 20 + int'(h_sx[c2]) / 32];
                    idx = (int'(h_sx[c2]) / 4) % 8;
                    check("pix", pix, (w >> (idx * 2)) & 3);
                end
            end

            h_rst[c0] = rst;   h_sx[c0] = sx;     h_sy[c0] = sy;
            h_de[c0]  = de;    h_hs[c0] = hsync;  h_vs[c0] = vsync;
            h_gnt[c0] = gnt;   h_gwe[c0] = hif.we;
            h_rdx[c0] = ref_fb[hif.addr];
            if (gnt && hif.we) ref_fb[hif.addr] = hif.wdata;
            mc++;
        end
    end

    // ---------------- directed stimulus ----------------
    int exp_pix [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        hif.req = 1'b1; hif.we = 1'b0; hif.addr = '0; hif.wdata = '0;
        rst = 1'b1; de = 1'b1; sx = '0; sy = '0; hsync = 1'b1; vsync = 1'b1;

        // Reset held with a pending host read and a display slot on the inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lit_rst_mem_re", mem_re, 0);
            check("lit_rst_mem_we", mem_we, 0);
            check("lit_rst_ack", hif.ack, 0);
            check("lit_rst_rvalid", hif.rvalid, 0);
            check("lit_rst_pix", pix, 0);
            check("lit_rst_pix_de", pix_de, 0);
            check("lit_rst_hsync", pix_hsync, 1);
            check("lit_rst_vsync", pix_vsync, 1);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; hif.req = 1'b0;
        blank(3);

        // Scanout of word 0 = E4E4 on line 0.
        pix_chk_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc_begin(i, 0, 1'b1, 1'b1, 1'b1);
            if (i == 0) begin
                check("lit_scan_re0", mem_re, 1);
                check("lit_scan_addr0", mem_addr, 0);
            end else if (i < 32) begin
                check("lit_scan_no_re", mem_re, 0);
            end
            if (i >= 2 && i < 34) check("lit_scan_pix", pix, exp_pix[(i - 2) / 4]);
            cyc_end();
        end
        pix_chk_en = 1'b0;
        blank(3);

        // Address arithmetic and absence of display reads off the slot.
        cyc_begin(32, 5, 1'b1, 1'b1, 1'b1);
        check("lit_addr_21_re", mem_re, 1);
        check("lit_addr_21", mem_addr, 21);
        cyc_end();
        for (int x = 33; x < 64; x++) begin
            cyc_begin(x, 5, 1'b1, 1'b1, 1'b1);
            check("lit_no_re_mid", mem_re, 0);
            cyc_end();
        end
        cyc_begin(608, 479, 1'b1, 1'b1, 1'b1);
        check("lit_addr_2399", mem_addr, 2399);
        cyc_end();
        cyc_begin(0, 10, 1'b0, 1'b1, 1'b1);
        check("lit_no_re_blank", mem_re, 0);
        cyc_end();
        blank(3);

        // Host write colliding with the display slot at sx=64.
        for (int x = 60; x <= 70; x++) begin
            if (x == 64) host_push(1'b1, 7, 16'h1234);
            cyc_begin(x, 0, 1'b1, 1'b1, 1'b1);
            if (x == 64) begin
                check("lit_col_disp_re", mem_re, 1);
                check("lit_col_disp_we", mem_we, 0);
                check("lit_col_disp_addr", mem_addr, 2);
            end else if (x == 65) begin
                check("lit_col_we", mem_we, 1);
                check("lit_col_addr", mem_addr, 7);
                check("lit_col_wdata", mem_wdata, 16'h1234);
            end else if (x == 66) begin
                check("lit_col_ack", hif.ack, 1);
                check("lit_col_turnaround", 32'(mem_re | mem_we), 0);
            end
            cyc_end();
        end
        blank(2);
        host_drain();

        // Host reads in blanking, back to back.
        host_push(1'b1, 100, 16'hBEEF);
        host_drain();
        host_push(1'b0, 100, 16'h0000);
        host_push(1'b0, 7, 16'h0000);
        for (int k = 0; k < 5; k++) begin
            cyc_begin(700, 500, 1'b0, 1'b1, 1'b1);
            case (k)
                0: begin
                    check("lit_rd_re", mem_re, 1);
                    check("lit_rd_addr", mem_addr, 100);
                end
                1: begin
                    check("lit_rd_ack", hif.ack, 1);
                    check("lit_rd_gap", 32'(mem_re | mem_we), 0);
                end
                2: begin
                    check("lit_rd_rvalid", hif.rvalid, 1);
                    check("lit_rd_rdata", hif.rdata, 16'hBEEF);
                    check("lit_rd2_re", mem_re, 1);
                    check("lit_rd2_addr", mem_addr, 7);
                end
                3: check("lit_rd2_ack", hif.ack, 1);
                default: begin
                    check("lit_rd2_rvalid", hif.rvalid, 1);
                    check("lit_rd2_rdata", hif.rdata, 16'h1234);
                end
            endcase
            cyc_end();
        end
        blank(2);

        // Reset the cycle after a host read grant: the read is dropped.
        host_push(1'b0, 100, 16'h0000);
        cyc_begin(700, 500, 1'b0, 1'b1, 1'b1);
        check("lit_mid_grant", mem_re, 1);
        cyc_end();
        rst = 1'b1;
        cycle(700, 500, 1'b0, 1'b1, 1'b1);
        cyc_begin(700, 500, 1'b0, 1'b1, 1'b1);
        check("lit_mid_no_rvalid", hif.rvalid, 0);
        cyc_end();
        cycle(700, 500, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        blank(3);
        check("lit_mid_queue_empty", 32'(hq.size() == 0 && !h_busy), 1);

        // Raster lines with background host traffic outside the displayed words.
        for (int i = 0; i < 30; i++) begin
            host_push(1'b1, 3000 + i, 16'($urandom));
            host_push(1'b0, 3000 + i, 16'h0000);
        end
        pix_chk_en = 1'b1;
        for (int y = 0; y < 8; y++) raster_line(y);
        for (int y = 476; y < 480; y++) raster_line(y);
        for (int y = 488; y < 492; y++) raster_line(y);
        pix_chk_en = 1'b0;
        blank(4);
        check("raster_host_done", 32'(hq.size() == 0 && !h_busy), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_checks++; n_fail++;
        $display("FAIL global_timeout: simulation exceeded 2 ms");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
